// File: rtl/reg_mov_pkg.sv
// ---------------------------------------------------------------------------
// reg_mov_pkg
// Purpose : Shared definitions for the MOV engine and its register bank.
//           This file holds the engine state enum, the default bank geometry,
//           the select value that names the memory source and the select-width
//           helper.
// Ports   : none (package)
// Config  : MEM_TIMEOUT_EN (consumed by reg_mov_unit, not by this package)
// ---------------------------------------------------------------------------
package reg_mov_pkg;

    // Default geometry: an 8-bit datapath with R0..R6 plus memory.
    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_NREG    = 7;
    localparam int DEFAULT_TIMEOUT = 15;

    // The source select value one past the last register names memory.
    localparam int MEM_SRC = DEFAULT_NREG;

    // Engine sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2
    } mov_state_e;

    // Select width that covers R0..R(nreg-1) plus the memory code nreg.
    function automatic int sel_width(input int nreg);
        return $clog2(nreg + 1);
    endfunction

endpackage

// File: rtl/reg_mov_unit_bank.sv
// ---------------------------------------------------------------------------
// reg_bank
// Purpose : NREG x WIDTH general register array for the MOV engine.
//           It has one synchronous write port, one registered read port for
//           the datapath and one combinational source tap. The engine uses
//           the tap to sample Rs on the cycle it accepts a command.
// Ports   :
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high; clears every register
//   wr_en      in   write strobe
//   wr_sel     in   [SEL_W]  destination register index
//   wr_data    in   [WIDTH]  write data
//   rd_sel     in   [SEL_W]  read-port select (>= NREG reads as zero)
//   rd_data    out  [WIDTH]  registered read data, one-cycle latency
//   src_sel    in   [SEL_W]  source tap select
//   src_data   out  [WIDTH]  combinational value of regs[src_sel] (zero if
//                            src_sel >= NREG)
// ---------------------------------------------------------------------------
module reg_bank
    import reg_mov_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NREG  = DEFAULT_NREG,
    parameter int SEL_W = sel_width(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [WIDTH-1:0] rd_data,
    input  logic [SEL_W-1:0] src_sel,
    output logic [WIDTH-1:0] src_data
);

    localparam logic [SEL_W-1:0] NREG_SEL = SEL_W'(NREG);

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    // Next-state of the array: hold everything and overlay the single write.
    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_sel < NREG_SEL)) begin
            regs_d[wr_sel] = wr_data;
        end
    end

    // Read port input. It samples regs_q, not regs_d, so a read and a write
    // of the same register on one edge return the old contents.
    always_comb begin
        rd_data_d = '0;
        if (rd_sel < NREG_SEL) begin
            rd_data_d = regs_q[rd_sel];
        end
    end

    // Source tap for the engine; selects outside the array read as zero.
    always_comb begin
        src_data = '0;
        if (src_sel < NREG_SEL) begin
            src_data = regs_q[src_sel];
        end
    end

    // Register array and read-port flop, both cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            regs_q    <= regs_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/reg_mov_unit.sv
// ---------------------------------------------------------------------------
// reg_mov_unit
// Purpose : Register bank with a sequenced MOV engine. A command copies
//           register Rs, or a word fetched from memory, into register Rd.
//           The engine sits between the instruction decoder
//           (MOV Rx,Ry / MOV Rx,[mem]) and the datapath.
// Ports   :
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high
//   mov_valid  in   command valid
//   mov_ready  out  command can be accepted (high only in IDLE)
//   mov_src    in   [SEL_W] source: 0..NREG-1 register, NREG memory
//   mov_dst    in   [SEL_W] destination register 0..NREG-1
//   mem_req    out  memory fetch request, held until mem_ack
//   mem_ack    in   memory data valid this cycle (ignored outside FETCH)
//   mem_data   in   [WIDTH] memory read data
//   rd_sel     in   [SEL_W] read-port select
//   rd_data    out  [WIDTH] registered read data
//   done       out  one-cycle pulse: MOV committed
//   err        out  one-cycle pulse: command rejected or fetch aborted
// Config  : MEM_TIMEOUT_EN - when defined, FETCH gives up after TIMEOUT
//           cycles without mem_ack, pulses err and writes nothing. When it
//           is undefined, FETCH waits for mem_ack indefinitely.
// ---------------------------------------------------------------------------
module reg_mov_unit
    import reg_mov_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int NREG    = DEFAULT_NREG,
    parameter int SEL_W   = sel_width(NREG),
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mov_valid,
    output logic             mov_ready,
    input  logic [SEL_W-1:0] mov_src,
    input  logic [SEL_W-1:0] mov_dst,
    output logic             mem_req,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_data,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             done,
    output logic             err
);

    // The memory code is the largest legal source select.
    localparam logic [SEL_W-1:0] MEM_SEL  = SEL_W'(NREG);
    localparam logic [SEL_W-1:0] NREG_SEL = SEL_W'(NREG);

    // A zero timeout would abort before a fetch could start.
    if (TIMEOUT < 1) begin : g_timeout_check
        $error("reg_mov_unit: TIMEOUT must be at least 1");
    end

    mov_state_e       state_q;
    mov_state_e       state_d;
    logic [SEL_W-1:0] dst_q;
    logic [SEL_W-1:0] dst_d;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] hold_d;
    logic             done_q;
    logic             done_d;
    logic             err_q;
    logic             err_d;

    logic             bank_we;
    logic [WIDTH-1:0] src_data;
    logic             src_too_big;
    logic             dst_illegal;

`ifdef MEM_TIMEOUT_EN
    localparam int             CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
`endif

    // Command legality. The source comparison is zero-extended by one bit.
    // When NREG+1 is a power of two, no SEL_W-bit source value can exceed
    // the memory code, and the wider compare keeps that case well-formed.
    assign src_too_big = ({1'b0, mov_src} > {1'b0, MEM_SEL});
    assign dst_illegal = (mov_dst >= NREG_SEL);

    // Register bank. The source tap feeds hold at accept time, so a
    // register-source MOV sees Rs as it was when the command was taken.
    reg_bank #(
        .WIDTH (WIDTH),
        .NREG  (NREG),
        .SEL_W (SEL_W)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (bank_we),
        .wr_sel   (dst_q),
        .wr_data  (hold_q),
        .rd_sel   (rd_sel),
        .rd_data  (rd_data),
        .src_sel  (mov_src),
        .src_data (src_data)
    );

    // Sequencer next-state and strobes. IDLE decodes the command. FETCH
    // waits for memory. WRITE commits hold into Rd and queues the done pulse
    // for the following cycle.
    always_comb begin
        state_d = state_q;
        dst_d   = dst_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        bank_we = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (mov_valid) begin
                    if (src_too_big || dst_illegal) begin
                        err_d = 1'b1;
                    end else if (mov_src == MEM_SEL) begin
                        dst_d   = mov_dst;
                        state_d = FETCH;
`ifdef MEM_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        dst_d   = mov_dst;
                        hold_d  = src_data;
                        state_d = WRITE;
                    end
                end
            end

            FETCH: begin
                if (mem_ack) begin
                    hold_d  = mem_data;
                    state_d = WRITE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    // Last allowed wait cycle has gone by without an ack.
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end

            WRITE: begin
                bank_we = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Engine state. Reset abandons any in-flight MOV and suppresses both
    // pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dst_q   <= '0;
            hold_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dst_q   <= dst_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Count of FETCH cycles that have gone by without mem_ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // mem_req follows the state directly. It drops on the edge that leaves
    // FETCH, whether through ack, abort or reset.
    assign mov_ready = (state_q == IDLE);
    assign mem_req   = (state_q == FETCH);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_reg_mov_unit.sv
// ---------------------------------------------------------------------------
// tb_reg_mov_unit
// Random and directed MOV traffic against a simple array model. Expected
// done/err events (with their cycle) and read-port values are queued when
// stimulus is issued. An independent monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_reg_mov_unit;

    localparam int WIDTH   = 8;
    localparam int NREG    = 7;
    localparam int SEL_W   = 3;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             mov_valid;
    logic             mov_ready;
    logic [SEL_W-1:0] mov_src;
    logic [SEL_W-1:0] mov_dst;
    logic             mem_req;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_data;
    logic [SEL_W-1:0] rd_sel;
    logic [WIDTH-1:0] rd_data;
    logic             done;
    logic             err;

    reg_mov_unit #(
        .WIDTH   (WIDTH),
        .NREG    (NREG),
        .SEL_W   (SEL_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mov_valid (mov_valid),
        .mov_ready (mov_ready),
        .mov_src   (mov_src),
        .mov_dst   (mov_dst),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Cycle number, advanced on every rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit is_err;
        int cyc;
    } evt_t;

    evt_t             evt_q[$];
    logic [WIDTH-1:0] rd_q[$];
    logic             rd_issue = 1'b0;
    logic             rd_chk   = 1'b0;
    logic [WIDTH-1:0] ref_regs [NREG];

    evt_t             mon_evt;
    logic [WIDTH-1:0] mon_rd;

    // A read issued in one cycle is compared in the next.
    always @(posedge clk) rd_chk <= rd_issue;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: checks read data and done/err pulses against the queues.
    always @(negedge clk) begin
        if (rd_chk) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL rd_unexpected: got 0x%0h with no expectation queued", rd_data);
            end else begin
                mon_rd = rd_q.pop_front();
                checkOutput("rd_data", 32'(rd_data), 32'(mon_rd));
            end
        end
        if (done === 1'b1 || err === 1'b1) begin
            n_checks++;
            if (evt_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL unexpected_event: got done=%b err=%b at cycle %0d, expected none", done, err, cyc);
            end else begin
                mon_evt = evt_q.pop_front();
                if (done !== !mon_evt.is_err || err !== mon_evt.is_err || cyc != mon_evt.cyc) begin
                    n_fail++;
                    $display("[TB] FAIL event: got done=%b err=%b at cycle %0d, expected done=%b err=%b at cycle %0d",
                             done, err, cyc, !mon_evt.is_err, mon_evt.is_err, mon_evt.cyc);
                end
            end
        end
    end

    task automatic pushEvt(input bit is_err, input int c);
        evt_t e;
        e.is_err = is_err;
        e.cyc    = c;
        evt_q.push_back(e);
    endtask

    // Waits (bounded) until every expected event has been seen.
    task automatic waitEvents();
        int t;
        t = 0;
        while (evt_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (evt_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL evt_timeout: %0d events outstanding, expected 0", evt_q.size());
            evt_q.delete();
        end
        @(posedge clk); #1;
    endtask

    // Reads every select value, including the one past the last register.
    task automatic readRegs();
        for (int i = 0; i <= NREG; i++) begin
            rd_sel   = SEL_W'(i);
            rd_issue = 1'b1;
            rd_q.push_back((i < NREG) ? ref_regs[i] : '0);
            @(posedge clk); #1;
        end
        rd_issue = 1'b0;
        @(posedge clk); #1;
    endtask

    // Issues one MOV and checks the handshake. ack_wait is the FETCH cycle
    // in which memory answers.
    task automatic applyStimulus(input int src, input int dst, input int ack_wait, input logic [WIDTH-1:0] data);
        int               issue;
        bit               legal;
        bit               is_mem;
        logic [WIDTH-1:0] old;
        legal  = (dst < NREG) && (src <= NREG);
        is_mem = (src == NREG);
        checkOutput("mov_ready_idle", 32'(mov_ready), 32'd1);
        mov_valid = 1'b1;
        mov_src   = SEL_W'(src);
        mov_dst   = SEL_W'(dst);
        issue     = cyc;
        if (!legal)      pushEvt(1'b1, issue + 1);
        else if (is_mem) pushEvt(1'b0, issue + 2 + ack_wait);
        else             pushEvt(1'b0, issue + 2);
        @(posedge clk); #1;
        mov_valid = 1'b0;
        if (!legal) begin
            @(negedge clk);
            checkOutput("mov_ready_after_err", 32'(mov_ready), 32'd1);
            checkOutput("mem_req_after_err", 32'(mem_req), 32'd0);
            @(posedge clk); #1;
        end else if (is_mem) begin
            checkOutput("mov_ready_busy", 32'(mov_ready), 32'd0);
            for (int j = 1; j <= ack_wait; j++) begin
                if (j == ack_wait) begin
                    mem_ack  = 1'b1;
                    mem_data = data;
                end
                @(negedge clk);
                checkOutput("mem_req_fetch", 32'(mem_req), 32'd1);
                @(posedge clk); #1;
            end
            mem_ack  = 1'b0;
            mem_data = ~data;
            @(negedge clk);
            checkOutput("mem_req_drop", 32'(mem_req), 32'd0);
            ref_regs[dst] = data;
        end else begin
            // Read Rd in the commit cycle: the old value must come back.
            old      = ref_regs[dst];
            rd_sel   = SEL_W'(dst);
            rd_issue = 1'b1;
            rd_q.push_back(old);
            @(negedge clk);
            checkOutput("mov_ready_busy", 32'(mov_ready), 32'd0);
            @(posedge clk); #1;
            rd_issue = 1'b0;
            ref_regs[dst] = ref_regs[src];
        end
        waitEvents();
    endtask

    initial begin
        int issue;
        int src;
        int dst;
        rst       = 1'b1;
        mov_valid = 1'b0;
        mov_src   = '0;
        mov_dst   = '0;
        mem_ack   = 1'b0;
        mem_data  = '0;
        rd_sel    = '0;
        for (int i = 0; i < NREG; i++) ref_regs[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("reset_mov_ready", 32'(mov_ready), 32'd1);
        checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        readRegs();

        $display("[TB] directed moves");
        applyStimulus(NREG, 2, 1, 8'hA5);
        applyStimulus(2, 5, 0, 8'h00);
        readRegs();
        applyStimulus(NREG, 3, 4, 8'h3C);
        applyStimulus(0, 7, 0, 8'h00);
        applyStimulus(NREG, 7, 0, 8'h00);
        applyStimulus(3, 3, 0, 8'h00);
        readRegs();

        $display("[TB] random moves");
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                mem_ack  = 1'b1;
                mem_data = WIDTH'($urandom);
                @(posedge clk); #1;
                mem_ack  = 1'b0;
            end
            src = int'($urandom_range(0, NREG));
            dst = int'($urandom_range(0, NREG));
            applyStimulus(src, dst, int'($urandom_range(1, 6)), WIDTH'($urandom));
            if (n % 8 == 7) readRegs();
        end
        readRegs();

        $display("[TB] reset during fetch");
        mov_valid = 1'b1;
        mov_src   = SEL_W'(NREG);
        mov_dst   = SEL_W'(6);
        @(posedge clk); #1;
        mov_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("mem_req_before_rst", 32'(mem_req), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("mem_req_after_rst", 32'(mem_req), 32'd0);
        checkOutput("mov_ready_after_rst", 32'(mov_ready), 32'd1);
        checkOutput("done_after_rst", 32'(done), 32'd0);
        for (int i = 0; i < NREG; i++) ref_regs[i] = '0;
        mem_ack  = 1'b1;
        mem_data = 8'hFF;
        @(posedge clk); #1;
        mem_ack  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("mem_req_stray_ack", 32'(mem_req), 32'd0);
        readRegs();

        $display("[TB] memory wait limit");
        applyStimulus(NREG, 1, 2, 8'h5A);
        mov_valid = 1'b1;
        mov_src   = SEL_W'(NREG);
        mov_dst   = SEL_W'(1);
        issue     = cyc;
`ifdef MEM_TIMEOUT_EN
        pushEvt(1'b1, issue + 1 + TIMEOUT);
        @(posedge clk); #1;
        mov_valid = 1'b0;
        waitEvents();
        checkOutput("mem_req_after_abort", 32'(mem_req), 32'd0);
        checkOutput("mov_ready_after_abort", 32'(mov_ready), 32'd1);
        readRegs();
`else
        @(posedge clk); #1;
        mov_valid = 1'b0;
        checkOutput("fetch_start_cycle", 32'(cyc), 32'(issue + 1));
        repeat (99) @(posedge clk);
        #1;
        checkOutput("mem_req_fetch_100", 32'(mem_req), 32'd1);
        checkOutput("mov_ready_fetch_100", 32'(mov_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < NREG; i++) ref_regs[i] = '0;
        readRegs();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
